// File: rtl/sc_io_master_pkg.sv
// Shared definitions for the switch-to-display bus initiator.
// Holds the default MMIO map, the controller state encoding and the
// active-low seven-segment code table used for the hex writes.
package sc_io_master_pkg;

    localparam logic [31:0] DEF_SW_ADDR  = 32'hffff_ff00;
    localparam logic [31:0] DEF_HEX_BASE = 32'hffff_ff20;
    localparam logic [31:0] DEF_LED_ADDR = 32'hffff_ff80;

    localparam int          NUM_HEX      = 6;
    localparam int          SW_W         = 10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_SW  = 3'd1,
        ST_CONV   = 3'd2,
        ST_WR_HEX = 3'd3,
        ST_WR_LED = 3'd4
    } state_t;

    // Active-low gfedcba pattern for one BCD digit; non-decimal codes blank.
    function automatic logic [6:0] seven_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sc_io_master_bin2bcd.sv
// bin2bcd_seq: sequential double-dabble converter, 10-bit binary to 4 BCD digits.
// Ports:
//   clock   in   system clock
//   resetn  in   synchronous active-low reset (control state only)
//   start   in   load request; ignored while a conversion is running
//   bin     in   10-bit value sampled on an accepted start
//   done    out  one-cycle pulse when bcd is valid
//   bcd     out  {thousands, hundreds, tens, ones}; held until the next start
// Timing: load on the start edge, then 10 shift edges; done is set on the
// last shift edge, so it is sampled 11 edges after start was sampled.
module bin2bcd_seq (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic [9:0]  bin,
    output logic        done,
    output logic [15:0] bcd
);

    logic [25:0] shreg;
    logic [3:0]  count;
    logic        active;
    logic [15:0] adj;

    // Add-3 correction on every BCD nibble that is 5 or more before shifting.
    always_comb begin
        adj = shreg[25:10];
        for (int i = 0; i < 4; i++) begin
            if (shreg[10 + i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = shreg[10 + i*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            active <= 1'b0;
            done   <= 1'b0;
            count  <= 4'd0;
        end else begin
            done <= 1'b0;
            if (active) begin
                count <= count - 4'd1;
                if (count == 4'd1) begin
                    active <= 1'b0;
                    done   <= 1'b1;
                end
            end else if (start) begin
                active <= 1'b1;
                count  <= 4'd10;
            end
        end
    end

    // Datapath needs no reset: it is always loaded before it is used.
    always_ff @(posedge clock) begin
        if (!active && start) begin
            shreg <= {16'd0, bin};
        end else if (active) begin
            shreg <= {adj, shreg[9:0]} << 1;
        end
    end

    assign bcd = shreg[25:10];

endmodule

// File: rtl/sc_io_master.sv
// sc_io_master: bus initiator that periodically reads the switch register,
// converts it to decimal and writes six seven-segment codes and the LEDs.
// Ports:
//   clock      in   system clock
//   resetn     in   synchronous active-low reset
//   enable     in   1 = periodic refresh runs; 0 = finish current refresh then idle
//   bus_grant  in   bus owned this cycle; an access completes only when high
//   dataout    in   read data from the memory block (combinational on addr)
//   bus_req    out  bus request (registered)
//   addr       out  bus address (registered)
//   datain     out  write data (registered)
//   we         out  write strobe; write state qualified by the current grant
//   busy       out  high whenever the controller is not idle
// The timer only runs while idle, so each idle gap is exactly PERIOD cycles.
module sc_io_master #(
    parameter int unsigned PERIOD   = 50000,
    parameter logic [31:0] SW_ADDR  = 32'hffff_ff00,
    parameter logic [31:0] HEX_BASE = 32'hffff_ff20,
    parameter logic [31:0] LED_ADDR = 32'hffff_ff80
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        enable,
    input  logic        bus_grant,
    input  logic [31:0] dataout,
    output logic        bus_req,
    output logic [31:0] addr,
    output logic [31:0] datain,
    output logic        we,
    output logic        busy
);

    import sc_io_master_pkg::*;

    localparam int TW = $clog2(PERIOD);

    state_t          state, state_nx;
    logic [TW-1:0]   timer, timer_nx;
    logic [2:0]      idx, idx_nx;
    logic [SW_W-1:0] sw_q, sw_nx;
    logic [15:0]     digits, digits_nx;
    logic            req_nx;
    logic [31:0]     addr_nx, datain_nx;

    logic            conv_start;
    logic            conv_done;
    logic [15:0]     conv_bcd;

    // Only the switch bits of the read word matter.
    logic            unused_dataout;
    assign unused_dataout = ^dataout[31:SW_W];

    // Digits 0..3 come from the BCD result; the two upper displays are blank.
    function automatic logic [6:0] hex_seg(input logic [15:0] dig, input logic [2:0] i);
        logic [6:0] s;
        case (i)
            3'd0:    s = seven_seg(dig[3:0]);
            3'd1:    s = seven_seg(dig[7:4]);
            3'd2:    s = seven_seg(dig[11:8]);
            3'd3:    s = seven_seg(dig[15:12]);
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // The converter loads straight from the bus on the granted read edge, so
    // the conversion overlaps the first CONV cycle and CONV lasts 11 cycles.
    bin2bcd_seq u_bin2bcd (
        .clock  (clock),
        .resetn (resetn),
        .start  (conv_start),
        .bin    (dataout[SW_W-1:0]),
        .done   (conv_done),
        .bcd    (conv_bcd)
    );

    always_comb begin
        state_nx   = state;
        timer_nx   = timer;
        idx_nx     = idx;
        sw_nx      = sw_q;
        digits_nx  = digits;
        conv_start = 1'b0;

        case (state)
            ST_IDLE: begin
                if (enable) begin
                    if (timer == TW'(PERIOD - 1)) begin
                        timer_nx = '0;
                        state_nx = ST_RD_SW;
                    end else begin
                        timer_nx = timer + 1'b1;
                    end
                end else begin
                    timer_nx = '0;
                end
            end
            ST_RD_SW: begin
                if (bus_grant) begin
                    sw_nx      = dataout[SW_W-1:0];
                    conv_start = 1'b1;
                    state_nx   = ST_CONV;
                end
            end
            ST_CONV: begin
                if (conv_done) begin
                    digits_nx = conv_bcd;
                    idx_nx    = 3'd0;
                    state_nx  = ST_WR_HEX;
                end
            end
            ST_WR_HEX: begin
                if (bus_grant) begin
                    if (idx == 3'(NUM_HEX - 1)) begin
                        state_nx = ST_WR_LED;
                    end else begin
                        idx_nx = idx + 3'd1;
                    end
                end
            end
            ST_WR_LED: begin
                if (bus_grant) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Registered bus outputs are decoded from the next state so they line up
    // with the state they belong to; a held access keeps the same values.
    always_comb begin
        req_nx    = 1'b0;
        addr_nx   = 32'd0;
        datain_nx = 32'd0;
        case (state_nx)
            ST_RD_SW: begin
                req_nx  = 1'b1;
                addr_nx = SW_ADDR;
            end
            ST_WR_HEX: begin
                req_nx    = 1'b1;
                addr_nx   = HEX_BASE + {25'd0, idx_nx, 4'd0};
                datain_nx = {25'd0, hex_seg(digits_nx, idx_nx)};
            end
            ST_WR_LED: begin
                req_nx    = 1'b1;
                addr_nx   = LED_ADDR;
                datain_nx = {22'd0, sw_nx};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            timer   <= '0;
            idx     <= 3'd0;
            sw_q    <= '0;
            digits  <= 16'd0;
            bus_req <= 1'b0;
            addr    <= 32'd0;
            datain  <= 32'd0;
        end else begin
            state   <= state_nx;
            timer   <= timer_nx;
            idx     <= idx_nx;
            sw_q    <= sw_nx;
            digits  <= digits_nx;
            bus_req <= req_nx;
            addr    <= addr_nx;
            datain  <= datain_nx;
        end
    end

    // The strobe must follow this cycle's grant, so it is gated combinationally.
    assign we   = bus_grant && ((state == ST_WR_HEX) || (state == ST_WR_LED));
    assign busy = (state != ST_IDLE);

endmodule
